// File: rtl/intadd_pkg.sv
// intadd_pkg: shared encodings and helpers
// for the SIMD integer add/sub pipeline.
package intadd_pkg;

  localparam logic [1:0] PREC_8   = 2'b00;
  localparam logic [1:0] PREC_16  = 2'b01;
  localparam logic [1:0] PREC_32  = 2'b11;
  localparam logic [1:0] PREC_RSV = 2'b10;

  typedef struct packed {
    logic [1:0] prec;
    logic       sgn;
    logic       sat;
    logic       sub;
  } mode_t;

  function automatic int lane_width(logic [1:0] prec);
    int w;
    case (prec)
      PREC_8:  w = 8;
      PREC_16: w = 16;
      PREC_32: w = 32;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic int lane_count(logic [1:0] prec, int data_w);
    if (prec == PREC_RSV) return 0;
    return data_w / lane_width(prec);
  endfunction

endpackage

// File: rtl/intadd_seg32.sv
// intadd_seg32: 32-bit segmented add/sub with
// carry kill at 8/16 boundaries and saturation.
module intadd_seg32
  import intadd_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  prec,
  input  logic        sgn,
  input  logic        sat,
  input  logic        sub,
  output logic [31:0] res,
  output logic [3:0]  ovf
);

  logic        p8, p16, p32;
  logic [31:0] bx;
  logic [31:0] sum;
  logic [4:0]  cc;
  logic [3:0]  first;
  logic [3:0]  last;
  logic [3:0]  lov;

  assign p8  = (prec == PREC_8);
  assign p16 = (prec == PREC_16);
  assign p32 = (prec == PREC_32);

  function automatic int end_byte(int k, logic m8, logic m16);
    if (m8)  return k;
    if (m16) return k | 1;
    return 3;
  endfunction

  // lane start/end byte markers for the current width
  always_comb begin
    first = '0;
    last  = '0;
    for (int k = 0; k < 4; k++) begin
      first[k] = (k == 0) || p8 || (p16 && k == 2);
      last[k]  = p8 || (p16 && (k % 2 == 1)) || (k == 3);
    end
  end

  // byte-wise carry chain; sub injects +1 at each lane start
  always_comb begin
    bx     = b ^ {32{sub}};
    sum    = '0;
    lov    = '0;
    cc     = '0;
    cc[0]  = sub;
    for (int k = 0; k < 4; k++) begin
      {cc[k+1], sum[8*k +: 8]} =
        {1'b0, a[8*k +: 8]} + {1'b0, bx[8*k +: 8]} +
        {8'd0, (first[k] ? sub : cc[k])};
      if (last[k]) begin
        if (sgn)
          lov[k] = (a[8*k+7] == bx[8*k+7]) &&
                   (sum[8*k+7] != a[8*k+7]);
        else
          lov[k] = cc[k+1] ^ sub;
      end
    end
  end

  // clamp overflowing lanes byte by byte
  always_comb begin
    res = sum;
    for (int k = 0; k < 4; k++) begin
      int e;
      logic an;
      e  = end_byte(k, p8, p16);
      an = a[8*e+7];
      if (sat && lov[e]) begin
        if (sgn) begin
          if (k == e) res[8*k +: 8] = an ? 8'h80 : 8'h7F;
          else        res[8*k +: 8] = an ? 8'h00 : 8'hFF;
        end else begin
          res[8*k +: 8] = sub ? 8'h00 : 8'hFF;
        end
      end
    end
  end

  // compact lane flags to lane index order
  always_comb begin
    ovf = '0;
    unique case (1'b1)
      p8:  ovf = lov;
      p16: ovf = {2'b00, lov[3], lov[1]};
      p32: ovf = {3'b000, lov[3]};
      default: ovf = '0;
    endcase
  end

endmodule

// File: rtl/intadd_simd_pipe.sv
// intadd_simd_pipe: 2-stage SIMD integer add/sub
// with lane saturation, flags and sticky status.
module intadd_simd_pipe
  import intadd_pkg::*;
#(
  parameter  int DATA_W = 128,
  localparam int NL     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src0,
  input  logic [DATA_W-1:0] src1,
  input  logic [1:0]        precision,
  input  logic              sign,
  input  logic              sat,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dst,
  output logic [NL-1:0]     ovf,
  output logic              err,
  output logic              sticky_ovf,
  input  logic              sticky_clr
);

  localparam int NSEG = DATA_W / 32;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  mode_t             s1_mode;

  logic              s2_load;
  logic              accept;
  logic              s1_p8, s1_p16, s1_p32, s1_rsv;

  logic [DATA_W-1:0] seg_res;
  logic [3:0]        seg_ovf [NSEG];
  logic [NL-1:0]     c_ovf;
  logic [NL-1:0]     lmask;
  logic [DATA_W-1:0] n_dst;
  logic [NL-1:0]     n_ovf;
  logic              n_err;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  assign s1_p8  = (s1_mode.prec == PREC_8);
  assign s1_p16 = (s1_mode.prec == PREC_16);
  assign s1_p32 = (s1_mode.prec == PREC_32);
  assign s1_rsv = (s1_mode.prec == PREC_RSV);

  genvar g;
  for (g = 0; g < NSEG; g++) begin : g_seg
    intadd_seg32 u_seg (
      .a    (s1_a[32*g +: 32]),
      .b    (s1_b[32*g +: 32]),
      .prec (s1_mode.prec),
      .sgn  (s1_mode.sgn),
      .sat  (s1_mode.sat),
      .sub  (s1_mode.sub),
      .res  (seg_res[32*g +: 32]),
      .ovf  (seg_ovf[g])
    );
  end

  // gather segment flags into global lane order
  always_comb begin
    c_ovf = '0;
    for (int s = 0; s < NSEG; s++) begin
      unique case (1'b1)
        s1_p8:  c_ovf[4*s +: 4] = seg_ovf[s];
        s1_p16: c_ovf[2*s +: 2] = seg_ovf[s][1:0];
        s1_p32: c_ovf[s]        = seg_ovf[s][0];
        default: ;
      endcase
    end
  end

  // stage-2 next values; unused flag bits forced low
  always_comb begin
    lmask = '0;
    for (int j = 0; j < NL; j++)
      lmask[j] = (j < lane_count(s1_mode.prec, DATA_W));
    n_dst = s1_rsv ? '0 : seg_res;
    n_ovf = s1_rsv ? '0 : (c_ovf & lmask);
    n_err = s1_rsv;
  end

  // stage 1: capture operands and mode on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= src0;
      s1_b     <= src1;
      s1_mode  <= '{precision, sign, sat, sub};
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // stage 2: result registers, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dst       <= '0;
      ovf       <= '0;
      err       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dst <= n_dst;
        ovf <= n_ovf;
        err <= n_err;
      end
    end
  end

  // sticky overflow: set on handshake, clear wins only alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_ovf <= 1'b0;
    else if (out_valid && out_ready)
      sticky_ovf <= (sticky_ovf && !sticky_clr) || (|ovf);
    else if (sticky_clr)
      sticky_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_intadd_simd_pipe.sv
// tb_intadd_simd_pipe: directed + random checks
// against a lane-level arithmetic model.
module tb_intadd_simd_pipe;

  localparam int DW = 128;
  localparam int NL = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] src0;
  logic [DW-1:0] src1;
  logic [1:0]    precision;
  logic          sign;
  logic          sat;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dst;
  logic [NL-1:0] ovf;
  logic          err;
  logic          sticky_ovf;
  logic          sticky_clr;

  intadd_simd_pipe #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src0       (src0),
    .src1       (src1),
    .precision  (precision),
    .sign       (sign),
    .sat        (sat),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dst        (dst),
    .ovf        (ovf),
    .err        (err),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [NL-1:0] o;
    logic          e;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  bit   sticky_m;

  task automatic check(string tag, logic [DW-1:0] obs,
                       logic [DW-1:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(logic [DW-1:0] a,
                                 logic [DW-1:0] b,
                                 logic [1:0] p, bit sg,
                                 bit st, bit sb);
    exp_t r;
    int w, n;
    longint mask, x, y, v, lo, hi;
    logic [DW-1:0] lane;
    r.d = '0;
    r.o = '0;
    r.e = 1'b0;
    if (p == 2'b10) begin
      r.e = 1'b1;
      return r;
    end
    w = (p == 2'b00) ? 8 : (p == 2'b01) ? 16 : 32;
    n = DW / w;
    mask = (64'sd1 <<< w) - 1;
    for (int i = 0; i < n; i++) begin
      x = longint'((a >> (i * w)) & DW'(mask));
      y = longint'((b >> (i * w)) & DW'(mask));
      if (sg) begin
        if (((x >>> (w - 1)) & 1) == 1) x = x - (mask + 1);
        if (((y >>> (w - 1)) & 1) == 1) y = y - (mask + 1);
        lo = -((mask + 1) / 2);
        hi = (mask + 1) / 2 - 1;
      end else begin
        lo = 0;
        hi = mask;
      end
      v = sb ? x - y : x + y;
      if (v < lo || v > hi) begin
        r.o[i] = 1'b1;
        if (st) begin
          if (sg) v = (x < 0) ? lo : hi;
          else    v = sb ? lo : hi;
        end
      end
      lane = DW'(v & mask);
      r.d  = r.d | (lane << (i * w));
    end
    return r;
  endfunction

  // scoreboard: push on accept, check head while valid
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      sticky_m = 1'b0;
    end else begin
      check("sticky", DW'(sticky_ovf), DW'(sticky_m));
      if (out_valid && q.size() == 0) begin
        check("unexpected_out", DW'(out_valid), '0);
      end else if (out_valid) begin
        check("dst", dst, q[0].d);
        check("ovf", DW'(ovf), DW'(q[0].o));
        check("err", DW'(err), DW'(q[0].e));
      end
      if (out_valid && out_ready && q.size() > 0) begin
        sticky_m = (sticky_m && !sticky_clr) || (|q[0].o);
        void'(q.pop_front());
      end else if (sticky_clr) begin
        sticky_m = 1'b0;
      end
      if (in_valid && in_ready)
        q.push_back(model(src0, src1, precision,
                          sign, sat, sub));
    end
  end

  task automatic rnd();
    int r;
    src0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    src1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    r = $urandom_range(0, 9);
    precision = (r == 0) ? 2'b10 : (r < 4) ? 2'b00 :
                (r < 7) ? 2'b01 : 2'b11;
    sign = 1'($urandom_range(0, 1));
    sat  = 1'($urandom_range(0, 1));
    sub  = 1'($urandom_range(0, 1));
  endtask

  task automatic run1(input logic [DW-1:0] a,
                      input logic [DW-1:0] b,
                      input logic [1:0] p, input bit sg,
                      input bit st, input bit sb,
                      input bit clr,
                      output logic [DW-1:0] d,
                      output logic [NL-1:0] o,
                      output logic e);
    src0 = a; src1 = b; precision = p;
    sign = sg; sat = st; sub = sb;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("lat2_valid", DW'(out_valid), DW'(1));
    d = dst; o = ovf; e = err;
    sticky_clr = clr;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
  endtask

  logic [DW-1:0] rd;
  logic [NL-1:0] ro;
  logic          re;
  bit            acc;
  bit [6:1]      expv;
  bit [5:0]      exprdy;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src0 = '0; src1 = '0; precision = '0;
    sign = 0; sat = 0; sub = 0; sticky_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_dst", dst, '0);
    check("rst_ovf", DW'(ovf), '0);
    check("rst_err", DW'(err), '0);
    check("rst_sticky", DW'(sticky_ovf), '0);
    check("rst_in_ready", DW'(in_ready), DW'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8-bit unsigned add: wrap then saturate
    run1({{15{8'h10}}, 8'hFF}, {{15{8'h20}}, 8'h01},
         2'b00, 0, 0, 0, 0, rd, ro, re);
    check("u8_wrap_dst", rd, {{15{8'h30}}, 8'h00});
    check("u8_wrap_ovf", DW'(ro), DW'(16'h0001));
    check("sticky_set", DW'(sticky_ovf), DW'(1));
    run1({{15{8'h10}}, 8'hFF}, {{15{8'h20}}, 8'h01},
         2'b00, 0, 1, 0, 1, rd, ro, re);
    check("u8_sat_dst", rd, {{15{8'h30}}, 8'hFF});
    check("u8_sat_ovf", DW'(ro), DW'(16'h0001));
    check("sticky_clr_hs", DW'(sticky_ovf), DW'(1));
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    check("sticky_clr_alone", DW'(sticky_ovf), '0);

    // 16-bit signed sub: saturate then wrap
    run1({96'h0, 16'h0005, 16'h8000},
         {96'h0, 16'h0007, 16'h0001},
         2'b01, 1, 1, 1, 0, rd, ro, re);
    check("s16_sat_dst", rd, {96'h0, 16'hFFFE, 16'h8000});
    check("s16_sat_ovf", DW'(ro), DW'(16'h0001));
    run1({96'h0, 16'h0005, 16'h8000},
         {96'h0, 16'h0007, 16'h0001},
         2'b01, 1, 0, 1, 0, rd, ro, re);
    check("s16_wrap_dst", rd, {96'h0, 16'hFFFE, 16'h7FFF});
    check("s16_wrap_ovf", DW'(ro), DW'(16'h0001));

    // 32-bit lanes, no carry into lane 1
    run1({96'h0, 32'h7FFFFFFF}, {96'h0, 32'h1},
         2'b11, 1, 1, 0, 0, rd, ro, re);
    check("s32_sat_dst", rd, {96'h0, 32'h7FFFFFFF});
    check("s32_sat_ovf", DW'(ro), DW'(16'h0001));
    run1({64'h0, 32'h5, 32'hFFFFFFFF}, {96'h0, 32'h1},
         2'b11, 0, 0, 0, 0, rd, ro, re);
    check("u32_wrap_dst", rd, {64'h0, 32'h5, 32'h0});
    check("u32_wrap_ovf", DW'(ro), DW'(16'h0001));

    // reserved precision, then a normal op
    run1({4{32'hDEADBEEF}}, {4{32'hFFFFFFFF}},
         2'b10, 0, 0, 0, 0, rd, ro, re);
    check("rsv_dst", rd, '0);
    check("rsv_ovf", DW'(ro), '0);
    check("rsv_err", DW'(re), DW'(1));
    run1({16{8'h01}}, {16{8'h02}},
         2'b00, 0, 0, 0, 0, rd, ro, re);
    check("after_rsv_err", DW'(re), '0);
    check("after_rsv_dst", rd, {16{8'h03}});

    // four back-to-back issues, latency 2
    expv = 6'b011110;
    out_ready = 1'b1;
    rnd();
    in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_valid_%0d", k),
            DW'(out_valid), DW'(expv[k]));
      if (k < 4) rnd();
      else in_valid = 1'b0;
    end

    // backpressure from empty: two buffered then stall
    exprdy = 6'b111011;
    rnd();
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      out_ready = (k >= 3);
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", k),
            DW'(in_ready), DW'(exprdy[k]));
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) rnd();
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      sticky_clr = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) rnd();
    end
    in_valid = 1'b0;
    sticky_clr = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain", DW'(q.size()), '0);

    // reset with two in flight
    rnd();
    in_valid = 1'b1;
    @(posedge clk); #1;
    rnd();
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", DW'(out_valid), '0);
    check("midrst_dst", dst, '0);
    check("midrst_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("postrst_idle_%0d", k),
            DW'(out_valid), '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
